// File: rtl/pkg_serial.sv
// Shared constants and state encodings for the host command receiver.
package pkg_serial;

  // ASCII characters understood by the command parser
  localparam logic [6:0] C_I    = 7'h49;
  localparam logic [6:0] C_A    = 7'h41;
  localparam logic [6:0] C_F    = 7'h46;
  localparam logic [6:0] C_L    = 7'h4C;
  localparam logic [6:0] C_HASH = 7'h23;
  localparam logic [6:0] C_ZERO = 7'h30;
  localparam logic [6:0] C_NINE = 7'h39;

  // UART receiver states
  typedef enum logic [2:0] {
    RxOcioso,
    RxInicio,
    RxDados,
    RxParidade,
    RxParada
  } estado_uart_t;

  // Parser states; values double as the debug display code
  typedef enum logic [3:0] {
    ParEspera = 4'h0,
    ParDig1   = 4'h1,
    ParDig2   = 4'h2,
    ParDig3   = 4'h3,
    ParFim    = 4'h4,
    ParErro   = 4'hF
  } estado_parser_t;

  function automatic logic is_digit(input logic [6:0] c);
    return (c >= C_ZERO) && (c <= C_NINE);
  endfunction

endpackage

// File: rtl/uart_rx_7o1.sv
// UART receiver: 7 data bits LSB first, odd parity, 1 stop bit.
module uart_rx_7o1
  import pkg_serial::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [6:0] dado,
  output logic       byte_ok,
  output logic       byte_erro
);

  localparam int unsigned DIV  = CLK_FREQ / BAUD;
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  logic         rx_meta, rx_sync;
  estado_uart_t estado;
  logic [CW-1:0] cnt;
  logic [2:0]   nbit;
  logic [6:0]   shift;
  logic         paridade;

  assign dado = shift;

  // Two-flop synchronizer; resets to idle-high so reset release never looks like a start bit
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Receiver FSM with baud counter and registered strobes
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado    <= RxOcioso;
      cnt       <= '0;
      nbit      <= '0;
      shift     <= '0;
      paridade  <= 1'b0;
      byte_ok   <= 1'b0;
      byte_erro <= 1'b0;
    end else begin
      byte_ok   <= 1'b0;
      byte_erro <= 1'b0;
      case (estado)
        RxOcioso: begin
          cnt <= '0;
          if (!rx_sync) estado <= RxInicio;
        end
        RxInicio: begin
          if (cnt == HALF_M1) begin
            cnt  <= '0;
            nbit <= '0;
            // A start bit that is gone by mid-bit was a glitch: drop it silently
            estado <= rx_sync ? RxOcioso : RxDados;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RxDados: begin
          if (cnt == DIV_M1) begin
            cnt   <= '0;
            shift <= {rx_sync, shift[6:1]};
            nbit  <= nbit + 1'b1;
            if (nbit == 3'd6) estado <= RxParidade;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RxParidade: begin
          if (cnt == DIV_M1) begin
            cnt      <= '0;
            paridade <= rx_sync;
            estado   <= RxParada;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RxParada: begin
          if (cnt == DIV_M1) begin
            cnt       <= '0;
            byte_ok   <= rx_sync & (^{shift, paridade});
            byte_erro <= ~(rx_sync & (^{shift, paridade}));
            estado    <= RxOcioso;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: estado <= RxOcioso;
      endcase
    end
  end

endmodule

// File: rtl/rx_comandos_serial.sv
// Host command receiver: UART front end plus ASCII command parser.
module rx_comandos_serial
  import pkg_serial::*;
#(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 115200,
  parameter logic [11:0] LIMIAR_RESET = 12'h050
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RX,
  output logic        cmd_iniciar,
  output logic        cmd_abre,
  output logic        cmd_fecha,
  output logic [11:0] limiar,
  output logic        limiar_valido,
  output logic        erro_rx,
  output logic [6:0]  db_dado,
  output logic [3:0]  db_estado_rx
);

  logic [6:0]     dado;
  logic           byte_ok, byte_erro;
  estado_parser_t estado;
  logic [3:0]     dig_c, dig_d, dig_u;

  uart_rx_7o1 #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_uart_rx (
    .clock     (clock),
    .reset     (reset),
    .rx        (RX),
    .dado      (dado),
    .byte_ok   (byte_ok),
    .byte_erro (byte_erro)
  );

  assign db_estado_rx = estado;

  // Parser FSM; all outputs registered, at most one pulse per received character
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado        <= ParEspera;
      cmd_iniciar   <= 1'b0;
      cmd_abre      <= 1'b0;
      cmd_fecha     <= 1'b0;
      limiar_valido <= 1'b0;
      limiar        <= LIMIAR_RESET;
      erro_rx       <= 1'b0;
      db_dado       <= '0;
      dig_c         <= '0;
      dig_d         <= '0;
      dig_u         <= '0;
    end else begin
      cmd_iniciar   <= 1'b0;
      cmd_abre      <= 1'b0;
      cmd_fecha     <= 1'b0;
      limiar_valido <= 1'b0;
      if (byte_erro) begin
        // Bad frame: abandon any partial 'L' sequence
        erro_rx <= 1'b1;
        estado  <= ParEspera;
      end else if (byte_ok) begin
        db_dado <= dado;
        case (estado)
          ParEspera: begin
            if (dado == C_I) begin
              cmd_iniciar <= 1'b1;
              erro_rx     <= 1'b0;
            end else if (dado == C_A) begin
              cmd_abre <= 1'b1;
              erro_rx  <= 1'b0;
            end else if (dado == C_F) begin
              cmd_fecha <= 1'b1;
              erro_rx   <= 1'b0;
            end else if (dado == C_L) begin
              estado <= ParDig1;
            end
          end
          ParDig1, ParDig2, ParDig3: begin
            if (is_digit(dado)) begin
              case (estado)
                ParDig1: begin dig_c <= dado[3:0]; estado <= ParDig2; end
                ParDig2: begin dig_d <= dado[3:0]; estado <= ParDig3; end
                default: begin dig_u <= dado[3:0]; estado <= ParFim;  end
              endcase
            end else begin
              erro_rx <= 1'b1;
              estado  <= ParErro;
            end
          end
          ParFim: begin
            if (dado == C_HASH) begin
              limiar        <= {dig_c, dig_d, dig_u};
              limiar_valido <= 1'b1;
              erro_rx       <= 1'b0;
              estado        <= ParEspera;
            end else begin
              erro_rx <= 1'b1;
              estado  <= ParErro;
            end
          end
          default: estado <= ParEspera;
        endcase
      end else if (estado == ParErro) begin
        estado <= ParEspera;
      end
    end
  end

endmodule

// File: tb/tb_rx_comandos_serial.sv
// Directed self-checking bench for rx_comandos_serial at default clock/baud.
module tb_rx_comandos_serial;

  localparam int DIV = 434;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        RX    = 1'b1;
  logic        cmd_iniciar, cmd_abre, cmd_fecha, limiar_valido, erro_rx;
  logic [11:0] limiar;
  logic [6:0]  db_dado;
  logic [3:0]  db_estado_rx;

  rx_comandos_serial dut (
    .clock         (clock),
    .reset         (reset),
    .RX            (RX),
    .cmd_iniciar   (cmd_iniciar),
    .cmd_abre      (cmd_abre),
    .cmd_fecha     (cmd_fecha),
    .limiar        (limiar),
    .limiar_valido (limiar_valido),
    .erro_rx       (erro_rx),
    .db_dado       (db_dado),
    .db_estado_rx  (db_estado_rx)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Pulse / state-change monitor, sampled mid-cycle
  int          n_ini = 0, n_abre = 0, n_fecha = 0, n_val = 0, n_ovl = 0, n_chg = 0;
  int          t_ini = 0;
  logic [31:0] hist = '0;
  logic [3:0]  last_st = 4'h0;
  always @(negedge clock) begin
    if (cmd_iniciar) begin n_ini++; t_ini = cyc; end
    if (cmd_abre) n_abre++;
    if (cmd_fecha) n_fecha++;
    if (limiar_valido) n_val++;
    if ((32'(cmd_iniciar) + 32'(cmd_abre) + 32'(cmd_fecha) + 32'(limiar_valido)) > 1) n_ovl++;
    if (db_estado_rx !== last_st) begin
      hist    = {hist[27:0], db_estado_rx};
      last_st = db_estado_rx;
      n_chg++;
    end
  end

  int errors = 0;
  int checks = 0;
  int t_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Sends the first nbits of a frame (10 = complete); bad_par inverts the parity bit
  task automatic send(input logic [6:0] d, input logic bad_par, input int nbits);
    logic [9:0] f;
    f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      RX = f[i];
      if (i == 0) t_start = cyc;
      idle(DIV);
    end
  endtask

  int s_ini, s_abre, s_fecha, s_val, s_chg;
  task automatic snap();
    s_ini = n_ini; s_abre = n_abre; s_fecha = n_fecha; s_val = n_val; s_chg = n_chg;
  endtask

  initial begin
    // Reset and long idle
    reset = 1'b0;
    idle(5);
    reset = 1'b1;
    idle(2000);
    check("rst_limiar", 32'(limiar), 32'h050);
    check("rst_erro", 32'(erro_rx), 32'd0);
    check("rst_estado", 32'(db_estado_rx), 32'd0);
    check("rst_dado", 32'(db_dado), 32'd0);
    check("rst_no_pulses", 32'(n_ini + n_abre + n_fecha + n_val), 32'd0);

    // 'I' -> one cmd_iniciar pulse about 9.5 bit periods after the start edge
    snap();
    send(7'h49, 1'b0, 10);
    idle(20);
    check("I_pulse", 32'(n_ini - s_ini), 32'd1);
    check("I_latency", 32'((t_ini - t_start) >= 4110 && (t_ini - t_start) <= 4140), 32'd1);
    check("I_dado", 32'(db_dado), 32'h49);
    check("I_others", 32'((n_abre - s_abre) + (n_fecha - s_fecha) + (n_val - s_val)), 32'd0);

    // 'L' with bad parity -> sticky error, limiar kept, db_dado not updated
    snap();
    send(7'h4C, 1'b1, 10);
    idle(20);
    check("Lpar_erro", 32'(erro_rx), 32'd1);
    check("Lpar_limiar", 32'(limiar), 32'h050);
    check("Lpar_estado", 32'(db_estado_rx), 32'd0);
    check("Lpar_dado", 32'(db_dado), 32'h49);

    // Good 'A' clears the error
    snap();
    send(7'h41, 1'b0, 10);
    idle(20);
    check("A_pulse", 32'(n_abre - s_abre), 32'd1);
    check("A_erro", 32'(erro_rx), 32'd0);

    // "L150#" back to back
    snap();
    send(7'h4C, 1'b0, 10);
    send(7'h31, 1'b0, 10);
    send(7'h35, 1'b0, 10);
    send(7'h30, 1'b0, 10);
    send(7'h23, 1'b0, 10);
    idle(20);
    check("L150_limiar", 32'(limiar), 32'h150);
    check("L150_valido", 32'(n_val - s_val), 32'd1);
    check("L150_states", 32'(hist[19:0]), 32'h12340);
    check("L150_nchg", 32'(n_chg - s_chg), 32'd5);
    check("L150_erro", 32'(erro_rx), 32'd0);
    check("L150_others", 32'((n_ini - s_ini) + (n_abre - s_abre) + (n_fecha - s_fecha)), 32'd0);

    // "L1X" then "#" -> parse error, '#' ignored in idle
    snap();
    send(7'h4C, 1'b0, 10);
    send(7'h31, 1'b0, 10);
    send(7'h58, 1'b0, 10);
    send(7'h23, 1'b0, 10);
    idle(20);
    check("L1X_limiar", 32'(limiar), 32'h150);
    check("L1X_erro", 32'(erro_rx), 32'd1);
    check("L1X_states", 32'(hist[15:0]), 32'h12F0);
    check("L1X_nchg", 32'(n_chg - s_chg), 32'd4);
    check("L1X_valido", 32'(n_val - s_val), 32'd0);
    check("L1X_dado", 32'(db_dado), 32'h23);

    // Reset during the data bits of 'F'
    snap();
    send(7'h46, 1'b0, 4);
    reset = 1'b0;
    idle(3);
    RX = 1'b1;
    idle(2);
    reset = 1'b1;
    idle(1);
    check("rstF_erro", 32'(erro_rx), 32'd0);
    check("rstF_limiar", 32'(limiar), 32'h050);
    check("rstF_dado", 32'(db_dado), 32'd0);
    check("rstF_estado", 32'(db_estado_rx), 32'd0);
    idle(2000);
    check("rstF_no_fecha", 32'(n_fecha - s_fecha), 32'd0);

    // Full 'F' after reset
    snap();
    send(7'h46, 1'b0, 10);
    idle(20);
    check("F_pulse", 32'(n_fecha - s_fecha), 32'd1);
    check("F_dado", 32'(db_dado), 32'h46);

    // 100-cycle low glitch is not a frame
    snap();
    RX = 1'b0;
    idle(100);
    RX = 1'b1;
    idle(5000);
    check("glitch_pulses", 32'((n_ini - s_ini) + (n_abre - s_abre) + (n_fecha - s_fecha) +
                               (n_val - s_val)), 32'd0);
    check("glitch_erro", 32'(erro_rx), 32'd0);
    check("glitch_dado", 32'(db_dado), 32'h46);
    check("glitch_estado", 32'(db_estado_rx), 32'd0);

    check("no_overlap", 32'(n_ovl), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_comandos_serial.md
Name: rx_comandos_serial

Overview:
- Receive side of the serial link between the water-tank controller and the host. The controller transmits distance frames on saida_serial; this block receives host commands on RX.
- A UART receiver (7 data bits, odd parity, 1 stop, LSB first) feeds an ASCII command parser.
- The parser produces single-cycle control pulses (start measurement, open/close valve override) and a 3-digit BCD alarm threshold for the level comparator.
- Sits beside circuito_projeto. Its outputs are OR'd into iniciar and used as the valve/buzzer reference.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- LIMIAR_RESET, 12'h050, BCD threshold loaded at reset (050 cm).

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low (0 = reset, sampled on clock edge).
- RX  in  1  asynchronous serial input; idle high.
- cmd_iniciar  out  1  1-cycle pulse when 'I' is received.
- cmd_abre  out  1  1-cycle pulse when 'A' is received (valve override open).
- cmd_fecha  out  1  1-cycle pulse when 'F' is received (valve override close).
- limiar  out  12  BCD threshold, 3 digits [11:8][7:4][3:0].
- limiar_valido  out  1  1-cycle pulse when limiar updates.
- erro_rx  out  1  sticky; set on parity, stop or parse error; cleared by the next good frame.
- db_dado  out  7  last received character.
- db_estado_rx  out  4  parser state code, for the hexa7seg debug display.

Behaviour:
- Reset (reset=0 at clock edge) has priority over everything, including a frame in flight:
  - all pulses 0, erro_rx=0, db_dado=0, limiar=LIMIAR_RESET;
  - both FSMs return to idle; counters 0.
- RX sync: 2-flop synchronizer. Line reset value 1, so no false start after reset.
- Bit period: DIV = CLK_FREQ/BAUD (434 at defaults). Half period = DIV/2 (217).
- Receiver FSM:
  - OCIOSO: synchronized RX=0 -> INICIO, counter cleared.
  - INICIO: after DIV/2 cycles, sample RX. If 0 -> DADOS. If 1 (glitch) -> OCIOSO, no error.
  - DADOS: sample every DIV cycles. 7 bits shifted in LSB first, then PARIDADE.
  - PARIDADE: sample once. Parity is OK when the XOR of the 7 data bits and the parity bit is 1 (odd).
  - PARADA: sample once. RX=1 means stop is OK.
  - Then a 1-cycle byte_ok or byte_erro strobe, and return to OCIOSO.
  - A new start is accepted from the cycle after the PARADA sample, so back-to-back frames are supported.
- Latency: the strobe occurs 1 cycle after the stop-bit sample, ≈ 9.5 bit periods after the start edge.
- Parser FSM (db_estado_rx codes: ESPERA=0, DIG1=1, DIG2=2, DIG3=3, FIM=4, ERRO=F). Acts on the byte_ok strobe:
  - ESPERA: 'I'(0x49), 'A'(0x41), 'F'(0x46) -> corresponding pulse in the cycle after the strobe; stay. 'L'(0x4C) -> DIG1. Any other character is ignored.
  - DIG1..DIG3: an ASCII digit '0'..'9' stores its low nibble into a shadow register (hundreds, tens, units) and advances. A non-digit goes to ERRO.
  - FIM: '#'(0x23) copies shadow to limiar and pulses limiar_valido. Anything else goes to ERRO. Both return to ESPERA (ERRO lasts one cycle, sets erro_rx).
  - byte_erro in any state sets erro_rx, drops the partial command (shadow discarded, limiar unchanged) and returns to ESPERA.
- Command characters arriving mid-'L' sequence are parse errors, not commands.
- Pulses never overlap: at most one output pulse per received character.
- erro_rx clears on the next byte_ok that completes a valid single-char command or a valid 'L' sequence.
- db_dado updates on every byte_ok.

Decomposition:
- Package pkg_serial holds:
  - ASCII constants: C_I, C_A, C_F, C_L, C_HASH, C_ZERO, C_NINE;
  - receiver state encodings;
  - parser state encodings (values above);
  - function is_digit.
- One sub-module, uart_rx_7o1: synchronizer, baud counter, receiver FSM, outputs dado[6:0], byte_ok, byte_erro.
- The parser stays in rx_comandos_serial.

Test Plan:
- Reset then idle RX=1 for 2000 cycles -> no pulses; limiar=12'h050; erro_rx=0; db_estado_rx=0.
- Send 'I' (data 1001001, parity 0, stop 1) -> exactly one cmd_iniciar pulse ≈ 4120 cycles after the start edge; db_dado=7'h49.
- Send "L150#" back-to-back ('1' p=0, '5' p=1, '0' p=1) -> limiar=12'h150 with one limiar_valido pulse after '#'; states 1,2,3,4,0 observed.
- Send 'L' with parity forced wrong -> erro_rx=1, limiar stays 050; a following good 'A' -> cmd_abre pulse and erro_rx=0.
- Send "L1X" then "#" -> ERRO after 'X', erro_rx=1, limiar unchanged; '#' ignored in ESPERA.
- Drop reset to 0 during the DADOS bits of 'F', then release -> no cmd_fecha; the next full 'F' produces exactly one pulse. A 100-cycle low glitch on RX -> no frame.
